bus_cycle_sequencer: RTL and testbench

- Two-requester bus master that arbitrates between port 0 (CPU) and port 1 (DMA).
- Runs 8086-style T1/T2/T3/Tw/T4 memory and I/O bus cycles, driving ALE, active-low RD/WR, IOM, address and write data.
- Sits upstream of the address-decode / OE-WD chip-select logic and supplies exactly the strobes that logic consumes.
- Inserts wait states from a READY input, with a timeout.

---
 rtl/bus_cycle_sequencer.sv | 252 +++++++++++++++++++++++++
 tb/tb_bus_cycle_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_sequencer.sv
// Two-port bus master that runs 8086-style memory/I-O bus cycles.
// Round-robin arbitration between port 0 (CPU) and port 1 (DMA), then a
// T1/T2/T3/Tw/T4 sequence with registered bus strobes and a READY wait timeout.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no cycle in flight; arbitration open
// T1    | ALE high, Address/IOM presented
// T2    | ALE low, RD or WR asserted, write data driven
// T3    | strobes held, READY sampled
// TW    | wait state, READY sampled, timeout counted
// T4    | strobes released, done/err/rdata presented; arbitration open
module bus_cycle_sequencer #(
   parameter int ADDR_W   = 20,
   parameter int DATA_W   = 16,
   parameter int WAIT_MAX = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic              iom0,
   input  logic              iom1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              busy,
   output logic              ALE,
   output logic              RD,
   output logic              WR,
   output logic              IOM,
   output logic [ADDR_W-1:0] Address,
   output logic [DATA_W-1:0] dout,
   output logic              dout_en,
   input  logic [DATA_W-1:0] din,
   input  logic              ready
);

   localparam int CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
   localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_T3   = 3'd3,
      S_TW   = 3'd4,
      S_T4   = 3'd5
   } state_t;

   state_t            state_q, state_n;
   logic              last_q, last_n;       // 1: port 1 was granted last
   logic              owner_q, owner_n;     // 1: port 1 owns the cycle
   logic              cyc_we_q, cyc_we_n;
   logic [DATA_W-1:0] cyc_wdata_q, cyc_wdata_n;
   logic [CNT_W-1:0]  cnt_q, cnt_n;

   logic              ale_q, ale_n;
   logic              rd_q, rd_n;
   logic              wr_q, wr_n;
   logic              iom_q, iom_n;
   logic [ADDR_W-1:0] addr_q, addr_n;
   logic [DATA_W-1:0] dout_q, dout_n;
   logic              dout_en_q, dout_en_n;
   logic              done0_q, done0_n;
   logic              done1_q, done1_n;
   logic              err_q, err_n;
   logic              busy_q, busy_n;
   logic [DATA_W-1:0] rdata_q, rdata_n;

   logic              arb_en;
   logic              pick1;
   logic              grant;
   logic              enter_t4;
   logic              timeout;
   logic              capture;

   // Round-robin pick; grant is combinational and suppressed while in reset
   always_comb begin
      arb_en = ((state_q == S_IDLE) || (state_q == S_T4)) && !rst;
      pick1  = req1 && (!req0 || !last_q);
      gnt1   = arb_en && pick1;
      gnt0   = arb_en && req0 && !pick1;
      grant  = gnt0 || gnt1;
   end

   // Next-state and next registered-output values
   always_comb begin
      state_n     = state_q;
      last_n      = last_q;
      owner_n     = owner_q;
      cyc_we_n    = cyc_we_q;
      cyc_wdata_n = cyc_wdata_q;
      cnt_n       = cnt_q;
      ale_n       = 1'b0;
      rd_n        = rd_q;
      wr_n        = wr_q;
      iom_n       = iom_q;
      addr_n      = addr_q;
      dout_n      = dout_q;
      dout_en_n   = dout_en_q;
      done0_n     = 1'b0;
      done1_n     = 1'b0;
      err_n       = 1'b0;
      busy_n      = busy_q;
      rdata_n     = rdata_q;
      enter_t4    = 1'b0;
      timeout     = 1'b0;
      capture     = 1'b0;

      case (state_q)
         S_IDLE: begin
         end
         S_T1: begin
            state_n = S_T2;
            if (cyc_we_q) begin
               wr_n      = 1'b0;
               dout_en_n = 1'b1;
               dout_n    = cyc_wdata_q;
            end else begin
               rd_n = 1'b0;
            end
         end
         S_T2: begin
            state_n = S_T3;
         end
         S_T3: begin
            if (ready) begin
               enter_t4 = 1'b1;
               capture  = 1'b1;
            end else if (WAIT_MAX > 0) begin
               state_n = S_TW;
               cnt_n   = CNT_W'(1);
            end else begin
               enter_t4 = 1'b1;
               timeout  = 1'b1;
            end
         end
         S_TW: begin
            if (ready) begin
               enter_t4 = 1'b1;
               capture  = 1'b1;
            end else if (cnt_q == WAIT_LIM) begin
               enter_t4 = 1'b1;
               timeout  = 1'b1;
            end else begin
               cnt_n = cnt_q + CNT_W'(1);
            end
         end
         S_T4: begin
            state_n = S_IDLE;
            busy_n  = 1'b0;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase

      // Release strobes and report completion as T4 is entered
      if (enter_t4) begin
         state_n   = S_T4;
         rd_n      = 1'b1;
         wr_n      = 1'b1;
         dout_en_n = 1'b0;
         done0_n   = !owner_q;
         done1_n   = owner_q;
         err_n     = timeout;
         if (capture && !cyc_we_q) begin
            rdata_n = din;
         end
      end

      // A grant (from IDLE or T4) latches the winner and starts T1
      if (grant) begin
         state_n     = S_T1;
         ale_n       = 1'b1;
         busy_n      = 1'b1;
         owner_n     = gnt1;
         last_n      = gnt1;
         cyc_we_n    = gnt1 ? we1 : we0;
         cyc_wdata_n = gnt1 ? wdata1 : wdata0;
         addr_n      = gnt1 ? addr1 : addr0;
         iom_n       = gnt1 ? iom1 : iom0;
      end
   end

   // State, cycle and bus-output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         last_q      <= 1'b1;
         owner_q     <= 1'b0;
         cyc_we_q    <= 1'b0;
         cyc_wdata_q <= '0;
         cnt_q       <= '0;
         ale_q       <= 1'b0;
         rd_q        <= 1'b1;
         wr_q        <= 1'b1;
         iom_q       <= 1'b0;
         addr_q      <= '0;
         dout_q      <= '0;
         dout_en_q   <= 1'b0;
         done0_q     <= 1'b0;
         done1_q     <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_n;
         last_q      <= last_n;
         owner_q     <= owner_n;
         cyc_we_q    <= cyc_we_n;
         cyc_wdata_q <= cyc_wdata_n;
         cnt_q       <= cnt_n;
         ale_q       <= ale_n;
         rd_q        <= rd_n;
         wr_q        <= wr_n;
         iom_q       <= iom_n;
         addr_q      <= addr_n;
         dout_q      <= dout_n;
         dout_en_q   <= dout_en_n;
         done0_q     <= done0_n;
         done1_q     <= done1_n;
         err_q       <= err_n;
         busy_q      <= busy_n;
         rdata_q     <= rdata_n;
      end
   end

   assign ALE     = ale_q;
   assign RD      = rd_q;
   assign WR      = wr_q;
   assign IOM     = iom_q;
   assign Address = addr_q;
   assign dout    = dout_q;
   assign dout_en = dout_en_q;
   assign done0   = done0_q;
   assign done1   = done1_q;
   assign err     = err_q;
   assign busy    = busy_q;
   assign rdata   = rdata_q;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Directed bench for bus_cycle_sequencer: main instance with WAIT_MAX=4,
// second instance with WAIT_MAX=0 for the no-wait-state timeout case.
module tb_bus_cycle_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1, req0_z;
   logic        we0, we1, iom0, iom1;
   logic [19:0] addr0, addr1;
   logic [15:0] wdata0, wdata1;
   logic [15:0] din;
   logic        ready;

   logic        gnt0, gnt1, done0, done1, err, busy;
   logic        ale, rd, wr, iom, dout_en;
   logic [19:0] address;
   logic [15:0] rdata, dout;

   logic        gnt0_z, gnt1_z, done0_z, done1_z, err_z, busy_z;
   logic        ale_z, rd_z, wr_z, iom_z, dout_en_z;
   logic [19:0] address_z;
   logic [15:0] rdata_z, dout_z;

   int checks   = 0;
   int failures = 0;
   int done0_seen = 0;
   int snap;

   always #5 clk = ~clk;

   bus_cycle_sequencer #(.ADDR_W(20), .DATA_W(16), .WAIT_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .iom0(iom0), .iom1(iom1), .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .rdata(rdata), .err(err), .busy(busy),
      .ALE(ale), .RD(rd), .WR(wr), .IOM(iom), .Address(address),
      .dout(dout), .dout_en(dout_en), .din(din), .ready(ready)
   );

   bus_cycle_sequencer #(.ADDR_W(20), .DATA_W(16), .WAIT_MAX(0)) dut_z (
      .clk(clk), .rst(rst),
      .req0(req0_z), .req1(1'b0), .we0(we0), .we1(we1),
      .iom0(iom0), .iom1(iom1), .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0_z), .gnt1(gnt1_z), .done0(done0_z), .done1(done1_z),
      .rdata(rdata_z), .err(err_z), .busy(busy_z),
      .ALE(ale_z), .RD(rd_z), .WR(wr_z), .IOM(iom_z), .Address(address_z),
      .dout(dout_z), .dout_en(dout_en_z), .din(din), .ready(ready)
   );

   always @(negedge clk) begin
      if (done0 === 1'b1) done0_seen++;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; req0 = 0; req1 = 0; req0_z = 0;
      we0 = 0; we1 = 0; iom0 = 0; iom1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      din = '0; ready = 1'b1;
      tick(); tick();
      chk("rst_ale", ale, 0);
      chk("rst_rd", rd, 1);
      chk("rst_wr", wr, 1);
      chk("rst_iom", iom, 0);
      chk("rst_addr", address, 0);
      chk("rst_dout_en", dout_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done0", done0, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_gnt0", gnt0, 0);
      rst = 1'b0;
      tick();

      // 1: port 0 memory read, no waits
      we0 = 0; iom0 = 0; addr0 = 20'h8_0010; din = 16'hA5A5; ready = 1;
      req0 = 1; #1;
      chk("t1_gnt0", gnt0, 1);
      chk("t1_gnt1", gnt1, 0);
      tick(); req0 = 0;
      chk("t1_ale_c1", ale, 1);
      chk("t1_addr_c1", address, 20'h8_0010);
      chk("t1_busy_c1", busy, 1);
      tick();
      chk("t1_ale_c2", ale, 0);
      chk("t1_rd_c2", rd, 0);
      chk("t1_wr_c2", wr, 1);
      tick();
      chk("t1_rd_c3", rd, 0);
      tick();
      chk("t1_done0_c4", done0, 1);
      chk("t1_rdata_c4", rdata, 16'hA5A5);
      chk("t1_err_c4", err, 0);
      chk("t1_rd_c4", rd, 1);
      chk("t1_wr_c4", wr, 1);
      tick();
      chk("t1_done0_c5", done0, 0);
      chk("t1_busy_c5", busy, 0);

      // 2: port 1 write with three wait states
      we1 = 1; iom1 = 0; addr1 = 20'h0_1234; wdata1 = 16'h3C3C; ready = 0;
      req1 = 1; #1;
      chk("t2_gnt1", gnt1, 1);
      tick(); req1 = 0;
      chk("t2_addr_c1", address, 20'h0_1234);
      chk("t2_ale_c1", ale, 1);
      tick();
      chk("t2_wr_c2", wr, 0);
      chk("t2_rd_c2", rd, 1);
      chk("t2_doe_c2", dout_en, 1);
      chk("t2_dout_c2", dout, 16'h3C3C);
      tick();
      chk("t2_wr_c3", wr, 0);
      tick();
      chk("t2_wr_c4", wr, 0);
      chk("t2_done1_c4", done1, 0);
      tick();
      chk("t2_doe_c5", dout_en, 1);
      chk("t2_done1_c5", done1, 0);
      tick(); ready = 1;
      chk("t2_wr_c6", wr, 0);
      chk("t2_dout_c6", dout, 16'h3C3C);
      chk("t2_done1_c6", done1, 0);
      tick();
      chk("t2_done1_c7", done1, 1);
      chk("t2_err_c7", err, 0);
      chk("t2_wr_c7", wr, 1);
      chk("t2_doe_c7", dout_en, 0);
      chk("t2_rdata_hold", rdata, 16'hA5A5);
      tick();
      chk("t2_done1_c8", done1, 0);

      // 3: simultaneous requests, round-robin and back-to-back
      we0 = 0; we1 = 0; addr0 = 20'h0_0100; addr1 = 20'h0_0200; din = 16'h5A5A;
      req0 = 1; req1 = 1; #1;
      chk("t3_gnt0_c0", gnt0, 1);
      chk("t3_gnt1_c0", gnt1, 0);
      tick(); req0 = 0;
      chk("t3_addr_c1", address, 20'h0_0100);
      tick(); tick(); tick();
      chk("t3_done0_c4", done0, 1);
      chk("t3_gnt1_c4", gnt1, 1);
      chk("t3_gnt0_c4", gnt0, 0);
      tick(); req1 = 0;
      chk("t3_ale_c5", ale, 1);
      chk("t3_busy_c5", busy, 1);
      chk("t3_addr_c5", address, 20'h0_0200);
      tick();
      addr0 = 20'h0_0300; req0 = 1; req1 = 1;
      tick(); tick();
      chk("t3_done1_c8", done1, 1);
      chk("t3_rdata_c8", rdata, 16'h5A5A);
      chk("t3_tie_gnt0", gnt0, 1);
      chk("t3_tie_gnt1", gnt1, 0);
      tick(); req0 = 0;
      chk("t3_addr_c9", address, 20'h0_0300);
      tick(); tick(); tick();
      chk("t3_done0_c12", done0, 1);
      chk("t3_gnt1_c12", gnt1, 1);
      tick(); req1 = 0;
      tick(); tick(); tick();
      chk("t3_done1_c16", done1, 1);
      tick();

      // 4a: timeout after exactly four wait states
      we0 = 0; addr0 = 20'h0_0400; din = 16'hFFFF; ready = 0;
      req0 = 1; #1;
      chk("t4_gnt0", gnt0, 1);
      tick(); req0 = 0;
      tick(); tick(); tick(); tick(); tick(); tick();
      chk("t4_rd_c7", rd, 0);
      chk("t4_done0_c7", done0, 0);
      tick();
      chk("t4_done0_c8", done0, 1);
      chk("t4_err_c8", err, 1);
      chk("t4_rdata_c8", rdata, 16'h5A5A);
      chk("t4_rd_c8", rd, 1);
      tick();
      chk("t4_err_c9", err, 0);

      // 4b: WAIT_MAX=0 instance times out straight from T3
      req0_z = 1; #1;
      chk("t4z_gnt0", gnt0_z, 1);
      tick(); req0_z = 0;
      tick(); tick();
      chk("t4z_rd_c3", rd_z, 0);
      tick();
      chk("t4z_done0_c4", done0_z, 1);
      chk("t4z_err_c4", err_z, 1);
      chk("t4z_rdata_c4", rdata_z, 0);
      chk("t4z_rd_c4", rd_z, 1);
      tick();

      // 5: reset during the second wait state
      addr0 = 20'h0_0500; ready = 0;
      req0 = 1; #1;
      chk("t5_gnt0", gnt0, 1);
      snap = done0_seen;
      tick(); req0 = 0;
      tick(); tick(); tick(); tick();
      chk("t5_rd_tw2", rd, 0);
      rst = 1;
      tick();
      chk("t5_rd_rst", rd, 1);
      chk("t5_busy_rst", busy, 0);
      chk("t5_addr_rst", address, 0);
      chk("t5_done0_rst", done0, 0);
      rst = 0;
      tick();
      chk("t5_no_done0", done0_seen, snap);
      addr0 = 20'h0_0600; din = 16'h1234; ready = 1;
      req0 = 1; #1;
      chk("t5_regnt0", gnt0, 1);
      tick(); req0 = 0;
      tick(); tick(); tick();
      chk("t5_done0", done0, 1);
      chk("t5_rdata", rdata, 16'h1234);
      chk("t5_err", err, 0);
      tick();

      // 6: IOM follows the owning cycle
      we1 = 0; iom1 = 1; addr1 = 20'hF_0F0F; din = 16'h0F0F;
      req1 = 1; #1;
      chk("t6_gnt1", gnt1, 1);
      tick(); req1 = 0;
      chk("t6_iom_c1", iom, 1);
      chk("t6_addr_c1", address, 20'hF_0F0F);
      iom0 = 0; addr0 = 20'h0_0707; we0 = 0; req0 = 1;
      tick();
      chk("t6_iom_c2", iom, 1);
      tick();
      chk("t6_iom_c3", iom, 1);
      tick();
      chk("t6_iom_c4", iom, 1);
      chk("t6_done1_c4", done1, 1);
      chk("t6_gnt0_c4", gnt0, 1);
      tick(); req0 = 0;
      chk("t6_iom_c5", iom, 0);
      chk("t6_addr_c5", address, 20'h0_0707);
      chk("t6_ale_c5", ale, 1);
      tick(); tick(); tick();
      chk("t6_done0_c8", done0, 1);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
